// File: rtl/onehot_dispatch_decoder.sv
// onehot_dispatch_decoder: takes an encoded winner index over valid/ready,
// drives a registered one-hot request line until the addressed agent acks.
// Optional watchdog: define DISPATCH_TIMEOUT_EN to abort unanswered requests.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     item handshake (ready only while idle)
//   in_code, in_idle      encoded line index, encoder-reported idle flag
//   ack[N]                per-line acknowledge from agents
//   out_onehot[N]         registered request, at most one bit set
//   busy                  a request is being driven
//   err_code              pulse: accepted code >= N
//   spurious_ack          pulse: ack on an undriven line
//   timeout               pulse: request aborted by watchdog
module onehot_dispatch_decoder #(
  parameter int N          = 8,
  parameter int W          = 3,
  parameter int TMO_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  input  logic         in_idle,
  input  logic [N-1:0] ack,
  output logic [N-1:0] out_onehot,
  output logic         busy,
  output logic         err_code,
  output logic         spurious_ack,
  output logic         timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [W:0]   NL  = N[W:0];
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t state;
  logic   xfer;
  logic   code_ok;
  logic   hit;

  // Gated by rst_n so the producer sees not-ready while reset is held.
  assign in_ready = rst_n & (state == IDLE);
  assign busy     = (state == DRIVE);
  assign xfer     = in_valid & in_ready;
  assign code_ok  = ({1'b0, in_code} < NL);
  // out_onehot has exactly the addressed bit set while driving.
  assign hit      = |(ack & out_onehot);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int            CW   = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_onehot   <= '0;
      err_code     <= 1'b0;
      spurious_ack <= 1'b0;
      timeout      <= 1'b0;
      cnt          <= '0;
    end else begin
      err_code     <= 1'b0;
      timeout      <= 1'b0;
      spurious_ack <= |(ack & ~out_onehot);
      unique case (1'b1)
        (state == IDLE): begin
          if (xfer && !in_idle) begin
            if (code_ok) begin
              state      <= DRIVE;
              out_onehot <= ONE << in_code;
              cnt        <= '0;
            end else begin
              err_code <= 1'b1;
            end
          end
        end
        (state == DRIVE): begin
          // Ack beats expiry when both land on the same edge.
          if (hit) begin
            state      <= IDLE;
            out_onehot <= '0;
          end else if (cnt == LAST) begin
            state      <= IDLE;
            out_onehot <= '0;
            timeout    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_onehot   <= '0;
      err_code     <= 1'b0;
      spurious_ack <= 1'b0;
    end else begin
      err_code     <= 1'b0;
      spurious_ack <= |(ack & ~out_onehot);
      unique case (1'b1)
        (state == IDLE): begin
          if (xfer && !in_idle) begin
            if (code_ok) begin
              state      <= DRIVE;
              out_onehot <= ONE << in_code;
            end else begin
              err_code <= 1'b1;
            end
          end
        end
        (state == DRIVE): begin
          if (hit) begin
            state      <= IDLE;
            out_onehot <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// Bench for onehot_dispatch_decoder: N=8 and N=6 instances, random
// stimulus against a line/age reference model, plus reset and long-hold.
module tb_onehot_dispatch_decoder;

  localparam int TMO = 4;

  logic       clk;
  logic       rst_n;

  logic       v8, i8, r8, b8, e8, s8, t8;
  logic [2:0] c8;
  logic [7:0] a8, o8;

  logic       v6, i6, r6, b6, e6, s6, t6;
  logic [2:0] c6;
  logic [5:0] a6, o6;

  onehot_dispatch_decoder #(
    .N(8), .W(3), .TMO_CYCLES(TMO)
  ) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(r8),
    .in_code(c8), .in_idle(i8),
    .ack(a8), .out_onehot(o8),
    .busy(b8), .err_code(e8),
    .spurious_ack(s8), .timeout(t8)
  );

  onehot_dispatch_decoder #(
    .N(6), .W(3), .TMO_CYCLES(TMO)
  ) u6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v6), .in_ready(r6),
    .in_code(c6), .in_idle(i6),
    .ack(a6), .out_onehot(o6),
    .busy(b6), .err_code(e6),
    .spurious_ack(s6), .timeout(t6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: line = driven index (-1 none), age = cycles it has been visible.
  bit v[2], idl[2], hold[2];
  int code[2], ackv[2], line[2], age[2];
  bit pe[2], ps[2], pt[2];

  function automatic int nof(int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic int ohof(int d);
    return (line[d] < 0) ? 0 : (1 << line[d]);
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    v8 = v[0]; i8 = idl[0];
    c8 = code[0][2:0]; a8 = ackv[0][7:0];
    v6 = v[1]; i6 = idl[1];
    c6 = code[1][2:0]; a6 = ackv[1][5:0];
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] g_oh;
      logic        g_b, g_r, g_e, g_s, g_t;
      g_oh = (d == 0) ? 32'(o8) : 32'(o6);
      g_b  = (d == 0) ? b8 : b6;
      g_r  = (d == 0) ? r8 : r6;
      g_e  = (d == 0) ? e8 : e6;
      g_s  = (d == 0) ? s8 : s6;
      g_t  = (d == 0) ? t8 : t6;
      check($sformatf("onehot%0d", d), g_oh, ohof(d));
      check($sformatf("busy%0d", d), 32'(g_b),
            32'(line[d] >= 0));
      check($sformatf("ready%0d", d), 32'(g_r),
            32'(line[d] < 0));
      check($sformatf("err%0d", d), 32'(g_e), 32'(pe[d]));
      check($sformatf("spur%0d", d), 32'(g_s), 32'(ps[d]));
      check($sformatf("tmo%0d", d), 32'(g_t), 32'(pt[d]));
    end
  endtask

  task automatic step(bit noack, int fc);
    int nl[2], na[2];
    bit npe[2], nps[2], npt[2], nh[2];
    @(negedge clk);
    compare();
    for (int d = 0; d < 2; d++) begin
      int mask, r;
      mask = (1 << nof(d)) - 1;
      if (!hold[d]) begin
        if (fc >= 0) begin
          v[d] = 1'b1; idl[d] = 1'b0; code[d] = fc;
        end else begin
          v[d]    = ($urandom_range(0, 9) < 6);
          idl[d]  = ($urandom_range(0, 5) == 0);
          code[d] = $urandom_range(0, 7);
        end
      end
      r = $urandom_range(0, 9);
      if (noack || r < 4) ackv[d] = 0;
      else if (r < 7) ackv[d] = ohof(d);
      else if (r < 8) ackv[d] = $urandom & mask;
      else ackv[d] = 1 << $urandom_range(0, nof(d) - 1);
    end
    drive();
    for (int d = 0; d < 2; d++) begin
      int mask;
      mask   = (1 << nof(d)) - 1;
      nps[d] = ((ackv[d] & ~ohof(d) & mask) != 0);
      npe[d] = 1'b0;
      npt[d] = 1'b0;
      nl[d]  = line[d];
      na[d]  = age[d];
      nh[d]  = v[d] && (line[d] >= 0);
      if (line[d] < 0) begin
        if (v[d] && !idl[d]) begin
          if (code[d] >= nof(d)) npe[d] = 1'b1;
          else begin
            nl[d] = code[d];
            na[d] = 1;
          end
        end
      end else if (ackv[d][line[d]]) begin
        nl[d] = -1;
`ifdef DISPATCH_TIMEOUT_EN
      end else if (age[d] == TMO) begin
        nl[d]  = -1;
        npt[d] = 1'b1;
`endif
      end else begin
        na[d] = age[d] + 1;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      line[d] = nl[d]; age[d] = na[d];
      pe[d] = npe[d]; ps[d] = nps[d];
      pt[d] = npt[d]; hold[d] = nh[d];
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; idl[d] = 1'b0; code[d] = 0;
      ackv[d] = 0; line[d] = -1; age[d] = 0;
      pe[d] = 1'b0; ps[d] = 1'b0; pt[d] = 1'b0;
      hold[d] = 1'b0;
    end
    drive();
    #1;
    check("rst_oh8", 32'(o8), 0);
    check("rst_oh6", 32'(o6), 0);
    check("rst_busy", 32'({b8, b6}), 0);
    check("rst_ready", 32'({r8, r6}), 0);
    check("rst_pulse", 32'({e8, s8, t8, e6, s6, t6}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; idl[d] = 1'b0; code[d] = 0;
      ackv[d] = 0; line[d] = -1; age[d] = 0;
      hold[d] = 1'b0;
    end
    drive();
    do_reset();
    // Reset while driving code 5 (8'h20).
    step(1'b1, 5);
    step(1'b1, -1);
    step(1'b1, -1);
    check("pre_rst_oh8", 32'(o8), 32'h20);
    do_reset();
    // Long withheld ack on code 5.
    step(1'b1, 5);
    for (int i = 0; i < 1000; i++) step(1'b1, -1);
    // Random traffic with a reset in the middle.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      step(1'b0, -1);
    end
    step(1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
